cla_serial_adder: RTL and testbench
===================================

Name: cla_serial_adder

Overview:
- Multi-cycle wide adder built around a single 8-bit carry-lookahead slice (cla_8bit).
- Takes a NUM_BYTES*8-bit operand pair plus carry-in through a start/ready handshake.
- Adds one byte per clock, least-significant byte first, with a registered inter-byte carry.
- Presents a registered sum and carry-out with a one-cycle done pulse. Trades latency for area against a fully-parallel cascade.

Parameters:
- NUM_BYTES, 4, number of 8-bit slices processed; operand width W = 8*NUM_BYTES; legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where ready=1.
- carry_start  input  1  carry-in, sampled with start.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- ready  output  1  high when idle and able to accept start.
- sum  output  W  registered result; stable between done pulses.
- carry_out  output  1  registered carry from the MSB slice.
- done  output  1  one-cycle pulse; sum/carry_out valid from this cycle on.

Behaviour:
- Reset (async, rst=1): state=IDLE, byte counter=0, internal carry=0, operand/work registers=0. Outputs: sum=0, carry_out=0, done=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE: ready=1.
  - On start=1, latch a, b into operand registers and carry_start into the carry register, clear counter, go to RUN.
  - On start=0, remain in IDLE.
- RUN: ready=0.
  - Each cycle, the slice adds a_reg[8*cnt+:8] + b_reg[8*cnt+:8] + carry_reg.
  - The 8-bit result is written to work_reg[8*cnt+:8], and the slice carry to carry_reg.
  - The counter increments.
  - When cnt==NUM_BYTES-1, this is the last slice: go to DONE, and on the same edge load sum<=final work value and carry_out<=final slice carry.
- DONE: done=1 for exactly one cycle, ready=0; then go to IDLE.
- Latency: start accepted at edge T; done high during the cycle after edge T+NUM_BYTES; ready high again after edge T+NUM_BYTES+1. Issue interval is NUM_BYTES+2 cycles.
- start while ready=0 is ignored; operands are not resampled and the in-flight result is unaffected.
- sum/carry_out change only on entry to DONE and on reset. They hold the last result through the IDLE and RUN of the next operation.
- Arithmetic is modulo 2^W. carry_out is the true W-bit carry; there is no overflow/sign flag.
- Counter width is clog2(NUM_BYTES); it never wraps past NUM_BYTES-1.
- rst asserted mid-operation aborts immediately to the reset values. No partial result is ever exposed.
- start held high continuously re-issues an operation each time ready=1.

Decomposition:
- Shared package contents:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - SLICE_W=8.
- Sub-module: one instance of cla_8bit as the datapath slice, driven by the byte-select mux and carry register.
- FSM, counter and registers live in cla_serial_adder.
- No other sub-modules.

Test Plan:
- NUM_BYTES=4, a=32'h12345678, b=32'h9ABCDEF0, carry_start=0, start pulsed at T -> done pulse in the cycle after edge T+4; sum=32'hACF13568, carry_out=0.
- a=32'hFFFFFFFF, b=32'h00000001, carry_start=0 -> ripple through all 4 slices; sum=32'h00000000, carry_out=1.
- a=0, b=0, carry_start=1 -> sum=32'h00000001, carry_out=0.
- Start a=1,b=1, then assert start with a=32'hFFFF0000, b=32'h0000FFFF during RUN -> second request ignored; sum=32'h00000002, exactly one done pulse.
- Assert rst two cycles into RUN -> immediately ready=1, sum=0, carry_out=0, done=0. A following start with a=5, b=7 -> sum=12.
- start held high for three operations with fresh operands each accept -> done pulses spaced exactly 6 cycles apart, each result correct.

Source files
------------

// File: rtl/cla_serial_adder_pkg.sv
// Shared constants for the byte-serial carry-lookahead adder.
package cla_serial_adder_pkg;

    localparam int unsigned SLICE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder slice; every carry is a flat generate/propagate product.
module cla_8bit
    import cla_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_c,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_c
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;
    logic               w_prod;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
    always_comb begin
        w_c    = '0;
        w_prod = 1'b0;
        w_c[0] = i_c;
        for (int i = 0; i < SLICE_W; i++) begin
            w_c[i+1] = w_g[i];
            w_prod   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_prod & w_g[j]);
                w_prod   = w_prod & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_prod & i_c);
        end
    end

    assign o_s = w_p ^ w_c[SLICE_W-1:0];
    assign o_c = w_c[SLICE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Wide adder that reuses one 8-bit CLA slice, one byte per clock, LSB first.
module cla_serial_adder
    import cla_serial_adder_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         carry_start,
    input  logic [SLICE_W*NUM_BYTES-1:0] a,
    input  logic [SLICE_W*NUM_BYTES-1:0] b,
    output logic                         ready,
    output logic [SLICE_W*NUM_BYTES-1:0] sum,
    output logic                         carry_out,
    output logic                         done
);

    localparam int unsigned W     = SLICE_W * NUM_BYTES;
    localparam int unsigned CNT_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

    logic [1:0]         r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
    logic               r_carry, w_carry_nx;
    logic [W-1:0]       r_a,     w_a_nx;
    logic [W-1:0]       r_b,     w_b_nx;
    logic [W-1:0]       r_work,  w_work_nx;
    logic [W-1:0]       r_sum,   w_sum_nx;
    logic               r_cout,  w_cout_nx;

    logic [SLICE_W-1:0] w_a_byte;
    logic [SLICE_W-1:0] w_b_byte;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;

    assign w_a_byte = r_a[SLICE_W*r_cnt +: SLICE_W];
    assign w_b_byte = r_b[SLICE_W*r_cnt +: SLICE_W];

    cla_8bit u_slice (
        .i_a (w_a_byte),
        .i_b (w_b_byte),
        .i_c (r_carry),
        .o_s (w_slice_sum),
        .o_c (w_slice_cout)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_carry_nx = r_carry;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_work_nx  = r_work;
        w_sum_nx   = r_sum;
        w_cout_nx  = r_cout;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nx     = a;
                    w_b_nx     = b;
                    w_carry_nx = carry_start;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_work_nx[SLICE_W*r_cnt +: SLICE_W] = w_slice_sum;
                w_carry_nx = w_slice_cout;
                if (r_cnt == LAST) begin
                    // Result becomes visible only once the MSB slice is folded in.
                    w_sum_nx   = w_work_nx;
                    w_cout_nx  = w_slice_cout;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_DONE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_carry <= w_carry_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_work  <= w_work_nx;
            r_sum   <= w_sum_nx;
            r_cout  <= w_cout_nx;
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed-vector bench for cla_serial_adder with NUM_BYTES=4.
module tb_cla_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        carry_start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        done;

    int n_vec;
    int n_err;

    cla_serial_adder #(
        .NUM_BYTES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .carry_start (carry_start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation; returns edges from accept to first done-high sample (-1 on timeout).
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                         output int lat);
        int k;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        a = ia; b = ib; carry_start = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; carry_start = 1'b0; a = '0; b = '0;
        #12;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", sum); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [31:0] va [3] = '{32'h12345678, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] vb [3] = '{32'h9ABCDEF0, 32'h00000001, 32'h00000000};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'hACF13568, 32'h00000000, 32'h00000001};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], lat);
            n_vec++; if (lat != 4) begin n_err++; $display("FAIL add%0d_latency got=%0d exp=4", i, lat); end
            n_vec++; if (sum !== es[i]) begin n_err++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum, es[i]); end
            n_vec++; if (carry_out !== ec[i]) begin n_err++; $display("FAIL add%0d_cout got=%b exp=%b", i, carry_out, ec[i]); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0 || ready !== 1'b1) begin
                n_err++; $display("FAIL add%0d_after_done done=%b ready=%b exp done=0 ready=1", i, done, ready);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int pulses;
        a = 32'h1; b = 32'h1; carry_start = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 32'hFFFF0000; b = 32'h0000FFFF;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL busy_ready got=%b exp=0", ready); end
        n_vec++; if (sum !== 32'h1) begin n_err++; $display("FAIL busy_hold_sum got=%h exp=00000001", sum); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) begin
                pulses++;
                n_vec++; if (sum !== 32'h2) begin n_err++; $display("FAIL busy_sum got=%h exp=00000002", sum); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_abort;
        int lat;
        a = 32'h3; b = 32'h3; carry_start = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", ready); end
        n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL abort_sum got=%h exp=0", sum); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL abort_cout got=%b exp=0", carry_out); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", done); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd5, 32'd7, 1'b0, lat);
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL abort_retry_latency got=%0d exp=4", lat); end
        n_vec++; if (sum !== 32'd12) begin n_err++; $display("FAIL abort_retry_sum got=%h exp=0000000c", sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [3] = '{32'h0000FFFF, 32'h80000000, 32'h11111111};
        logic [31:0] vb [3] = '{32'h00000001, 32'h80000000, 32'h22222222};
        logic [31:0] es [3] = '{32'h00010000, 32'h00000000, 32'h33333333};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        int issued, ndone, last_t;
        issued = 0; ndone = 0; last_t = 0;
        carry_start = 1'b0;
        for (int t = 0; t < 40 && ndone < 3; t++) begin
            if (done) begin
                n_vec++; if (sum !== es[ndone] || carry_out !== ec[ndone]) begin
                    n_err++; $display("FAIL b2b%0d_result got=%h/%b exp=%h/%b",
                                      ndone, sum, carry_out, es[ndone], ec[ndone]);
                end
                if (ndone > 0) begin
                    n_vec++; if (t - last_t != 6) begin
                        n_err++; $display("FAIL b2b%0d_spacing got=%0d exp=6", ndone, t - last_t);
                    end
                end
                last_t = t;
                ndone++;
            end
            if (ready) begin
                if (issued < 3) begin
                    a = va[issued]; b = vb[issued]; start = 1'b1;
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++; if (ndone != 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
